// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter between the writeback stage and a 2-entry
// buffer of multi-cycle results, with age-forced draining and a pending scoreboard.
//
// state | meaning
// PIPE  | writeback has priority; buffered results use idle write slots
// DRAIN | buffer head owns the write port until empty or two entries retired
module rf_write_arbiter #(
   parameter int AGE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [3:0]  wb_addr,
   input  logic [15:0] wb_data,
   output logic        wb_stall,
   input  logic        mc_issue,
   input  logic [3:0]  mc_issue_addr,
   input  logic        mc_valid,
   input  logic [3:0]  mc_addr,
   input  logic [15:0] mc_data,
   output logic        mc_ready,
   output logic        rf_we,
   output logic [3:0]  rf_waddr,
   output logic [15:0] rf_wdata,
   output logic [15:0] pending
);

   localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

   typedef enum logic {
      PIPE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_WB   = 2'd1,
      SRC_FIFO = 2'd2
   } src_t;

   state_t      state, state_nxt;
   src_t        grant;
   logic        drain_pops, drain_pops_nxt;

   logic [3:0]  fifo_addr [2];
   logic [15:0] fifo_data [2];
   logic        head, head_nxt;
   logic [1:0]  count, count_nxt;
   logic        wr_idx;
   logic        push, pop;
   logic [3:0]  age, age_nxt;

   logic        rf_from_fifo;
   logic [15:0] pending_nxt;

   // Buffer admission looks at occupancy only, never at a same-cycle pop.
   assign mc_ready = !rst && (count != 2'd2);
   assign push     = mc_valid && mc_ready;

   always_comb begin
      grant = SRC_NONE;
      if (!rst) begin
         if (state == DRAIN && count != 2'd0)
            grant = SRC_FIFO;
         else if (wb_valid)
            grant = SRC_WB;
         else if (count != 2'd0)
            grant = SRC_FIFO;
      end
   end

   assign pop      = (grant == SRC_FIFO);
   assign wb_stall = wb_valid && (grant != SRC_WB);

   // New entry lands behind the head; with a simultaneous pop at one entry it becomes the head.
   assign wr_idx   = count[0] ? ~head : head;
   assign head_nxt = pop ? ~head : head;

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 2'd1;
         2'b01:   count_nxt = count - 2'd1;
         default: count_nxt = count;
      endcase
   end

   always_comb begin
      age_nxt = age;
      if (pop || count_nxt == 2'd0)
         age_nxt = 4'd0;
      else if (age != AGE_MAX)
         age_nxt = age + 4'd1;
   end

   always_comb begin
      state_nxt      = state;
      drain_pops_nxt = drain_pops;
      case (state)
         PIPE: begin
            if (count == 2'd2 || age == AGE_MAX) begin
               state_nxt      = DRAIN;
               drain_pops_nxt = 1'b0;
            end
         end
         DRAIN: begin
            if (count_nxt == 2'd0 || (pop && drain_pops)) begin
               state_nxt      = PIPE;
               drain_pops_nxt = 1'b0;
            end else if (pop) begin
               drain_pops_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt      = PIPE;
            drain_pops_nxt = 1'b0;
         end
      endcase
   end

   // Set wins: a re-issue in the same cycle as the retiring write keeps the bit.
   always_comb begin
      pending_nxt = pending;
      if (rf_we && rf_from_fifo)
         pending_nxt[rf_waddr] = 1'b0;
      if (mc_issue)
         pending_nxt[mc_issue_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= PIPE;
         drain_pops <= 1'b0;
         head       <= 1'b0;
         count      <= 2'd0;
         age        <= 4'd0;
         pending    <= 16'h0000;
      end else begin
         state      <= state_nxt;
         drain_pops <= drain_pops_nxt;
         head       <= head_nxt;
         count      <= count_nxt;
         age        <= age_nxt;
         pending    <= pending_nxt;
      end
   end

   // Storage is unreset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_idx] <= mc_addr;
         fifo_data[wr_idx] <= mc_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we        <= 1'b0;
         rf_waddr     <= 4'd0;
         rf_wdata     <= 16'h0000;
         rf_from_fifo <= 1'b0;
      end else begin
         rf_we        <= (grant != SRC_NONE);
         rf_from_fifo <= pop;
         if (grant == SRC_WB) begin
            rf_waddr <= wb_addr;
            rf_wdata <= wb_data;
         end else if (grant == SRC_FIFO) begin
            rf_waddr <= fifo_addr[head];
            rf_wdata <= fifo_data[head];
         end
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rf_write_arbiter;

   localparam int AGE_LIMIT = 4;

   logic        clk;
   logic        rst;
   logic        wb_valid;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        wb_stall;
   logic        mc_issue;
   logic [3:0]  mc_issue_addr;
   logic        mc_valid;
   logic [3:0]  mc_addr;
   logic [15:0] mc_data;
   logic        mc_ready;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic [15:0] pending;

   int n_assert = 0;
   int n_fail   = 0;

   rf_write_arbiter #(.AGE_LIMIT(AGE_LIMIT)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
      .mc_issue(mc_issue), .mc_issue_addr(mc_issue_addr),
      .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data), .mc_ready(mc_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [3:0]  m_q_addr [$];
   logic [15:0] m_q_data [$];
   int          m_age;
   bit          m_drain;
   int          m_drain_pops;
   logic [15:0] m_pend;
   logic        m_we;
   logic [3:0]  m_waddr;
   logic [15:0] m_wdata;
   bit          m_we_fifo;
   bit          m_live = 0;

   // 0 = nobody, 1 = writeback, 2 = buffered result
   function automatic int m_grant();
      if (rst) return 0;
      if (m_drain && m_q_addr.size() > 0) return 2;
      if (wb_valid) return 1;
      if (m_q_addr.size() > 0) return 2;
      return 0;
   endfunction

   always @(posedge clk) begin
      int g;
      int n0;
      int a0;
      bit popped;
      if (rst) begin
         m_q_addr.delete();
         m_q_data.delete();
         m_age = 0; m_drain = 0; m_drain_pops = 0;
         m_pend = 16'h0000; m_we = 0; m_waddr = 4'd0; m_wdata = 16'h0000;
         m_we_fifo = 0; m_live = 1;
      end else if (m_live) begin
         g  = m_grant();
         n0 = m_q_addr.size();
         a0 = m_age;
         if (m_we && m_we_fifo) m_pend[m_waddr] = 1'b0;
         if (mc_issue) m_pend[mc_issue_addr] = 1'b1;
         m_we      = (g != 0);
         m_we_fifo = (g == 2);
         popped    = (g == 2);
         if (g == 1) begin
            m_waddr = wb_addr;
            m_wdata = wb_data;
         end else if (g == 2) begin
            m_waddr = m_q_addr.pop_front();
            m_wdata = m_q_data.pop_front();
         end
         if (mc_valid && n0 < 2) begin
            m_q_addr.push_back(mc_addr);
            m_q_data.push_back(mc_data);
         end
         if (popped || m_q_addr.size() == 0) m_age = 0;
         else if (m_age < AGE_LIMIT) m_age++;
         if (!m_drain) begin
            if (n0 == 2 || a0 == AGE_LIMIT) begin
               m_drain = 1; m_drain_pops = 0;
            end
         end else begin
            if (popped) m_drain_pops++;
            if (m_q_addr.size() == 0 || m_drain_pops == 2) begin
               m_drain = 0; m_drain_pops = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      int g;
      if (m_live) begin
         g = m_grant();
         chk("wb_stall", 32'(wb_stall), 32'(wb_valid && g != 1));
         chk("mc_ready", 32'(mc_ready), 32'(!rst && m_q_addr.size() < 2));
         chk("rf_we",    32'(rf_we),    32'(m_we));
         chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
         chk("rf_wdata", 32'(rf_wdata), 32'(m_wdata));
         chk("pending",  32'(pending),  32'(m_pend));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      wb_valid = 1'b0; wb_addr = 4'd0; wb_data = 16'h0000;
      mc_issue = 1'b0; mc_issue_addr = 4'd0;
      mc_valid = 1'b0; mc_addr = 4'd0; mc_data = 16'h0000;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_rf_we", 32'(rf_we), 32'd0);
      chk("reset_pending", 32'(pending), 32'h0);
      chk("reset_waddr", 32'(rf_waddr), 32'd0);
      #1;
      chk("reset_mc_ready", 32'(mc_ready), 32'd1);

      // single writeback, empty buffer
      wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 16'h00AA;
      #1;
      chk("wb_single_stall", 32'(wb_stall), 32'd0);
      tick();
      wb_valid = 1'b0;
      chk("wb_single_we", 32'(rf_we), 32'd1);
      chk("wb_single_addr", 32'(rf_waddr), 32'd3);
      chk("wb_single_data", 32'(rf_wdata), 32'h00AA);
      tick();
      chk("wb_single_we_off", 32'(rf_we), 32'd0);

      // multi-cycle result, 2-cycle latency, pending set then cleared
      mc_issue = 1'b1; mc_issue_addr = 4'd5;
      tick();
      mc_issue = 1'b0;
      chk("mc_pend_set", 32'(pending[5]), 32'd1);
      mc_valid = 1'b1; mc_addr = 4'd5; mc_data = 16'h1234;
      tick();
      mc_valid = 1'b0;
      chk("mc_lat1_we", 32'(rf_we), 32'd0);
      tick();
      chk("mc_lat2_we", 32'(rf_we), 32'd1);
      chk("mc_lat2_addr", 32'(rf_waddr), 32'd5);
      chk("mc_lat2_data", 32'(rf_wdata), 32'h1234);
      chk("mc_pend_still", 32'(pending[5]), 32'd1);
      tick();
      chk("mc_pend_clr", 32'(pending[5]), 32'd0);

      // continuous writeback, one buffered result forced out by age
      wb_valid = 1'b1; wb_addr = 4'd1; wb_data = 16'h1111;
      mc_valid = 1'b1; mc_addr = 4'd9; mc_data = 16'h9999;
      #1;
      chk("age_push_stall", 32'(wb_stall), 32'd0);
      tick();
      mc_valid = 1'b0;
      for (int i = 0; i < AGE_LIMIT; i++) begin
         #1;
         chk("age_wb_stall", 32'(wb_stall), 32'd0);
         tick();
         chk("age_wb_addr", 32'(rf_waddr), 32'd1);
      end
      #1;
      chk("age_drain_stall", 32'(wb_stall), 32'd1);
      tick();
      chk("age_drain_addr", 32'(rf_waddr), 32'd9);
      chk("age_drain_data", 32'(rf_wdata), 32'h9999);
      #1;
      chk("age_resume_stall", 32'(wb_stall), 32'd0);
      tick();
      chk("age_resume_addr", 32'(rf_waddr), 32'd1);
      wb_valid = 1'b0;
      tick();

      // two results back to back fill the buffer, drained back to back
      wb_valid = 1'b1; wb_addr = 4'd2; wb_data = 16'h2222;
      mc_issue = 1'b1; mc_issue_addr = 4'd2;
      mc_valid = 1'b1; mc_addr = 4'hA; mc_data = 16'hAAAA;
      tick();
      mc_issue = 1'b0;
      mc_addr = 4'hB; mc_data = 16'hBBBB;
      #1;
      chk("full_ready_one", 32'(mc_ready), 32'd1);
      tick();
      mc_valid = 1'b0;
      #1;
      chk("full_ready_two", 32'(mc_ready), 32'd0);
      chk("full_stall_pipe", 32'(wb_stall), 32'd0);
      tick();
      #1;
      chk("full_stall_d1", 32'(wb_stall), 32'd1);
      tick();
      chk("full_pop_a", 32'(rf_waddr), 32'hA);
      chk("full_pop_a_data", 32'(rf_wdata), 32'hAAAA);
      #1;
      chk("full_stall_d2", 32'(wb_stall), 32'd1);
      tick();
      chk("full_pop_b", 32'(rf_waddr), 32'hB);
      #1;
      chk("full_stall_end", 32'(wb_stall), 32'd0);
      tick();
      chk("full_wb_resume", 32'(rf_waddr), 32'd2);
      chk("wb_keeps_pending", 32'(pending[2]), 32'd1);
      wb_valid = 1'b0;
      tick();

      // re-issue coincides with the retiring write of the same register
      mc_issue = 1'b1; mc_issue_addr = 4'd7;
      tick();
      mc_issue = 1'b0;
      mc_valid = 1'b1; mc_addr = 4'd7; mc_data = 16'h7777;
      tick();
      mc_valid = 1'b0;
      tick();
      chk("reissue_write_addr", 32'(rf_waddr), 32'd7);
      mc_issue = 1'b1; mc_issue_addr = 4'd7;
      tick();
      mc_issue = 1'b0;
      chk("reissue_pend_kept", 32'(pending[7]), 32'd1);

      // reset with a full buffer drops the buffered results
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mc_issue = 1'b1; mc_issue_addr = 4'd5;
      tick();
      mc_issue_addr = 4'd6;
      tick();
      mc_issue = 1'b0;
      chk("rst_pend_pre", 32'(pending), 32'h0060);
      wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 16'h0F0F;
      mc_valid = 1'b1; mc_addr = 4'd5; mc_data = 16'h5555;
      tick();
      mc_addr = 4'd6; mc_data = 16'h6666;
      tick();
      mc_valid = 1'b0;
      chk("rst_reg0_write", 32'(rf_waddr), 32'd0);
      #1;
      chk("rst_full_ready", 32'(mc_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_mc_ready", 32'(mc_ready), 32'd0);
      chk("rst_wb_stall", 32'(wb_stall), 32'd1);
      tick();
      rst = 1'b0;
      wb_valid = 1'b0;
      chk("rst_pend_clr", 32'(pending), 32'h0);
      chk("rst_we_clr", 32'(rf_we), 32'd0);
      #1;
      chk("rst_ready_back", 32'(mc_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rst_no_ghost_write", 32'(rf_we), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter: AGE_LIMIT, default 4, max cycles a buffered result waits before forcing the write port (range 1..15).
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: wb_valid  input  1  writeback stage holds a result to write.
REQ-005 SHALL have ports: wb_addr  input  4  writeback destination register.
REQ-006 SHALL have ports: wb_data  input  16  writeback data.
REQ-007 SHALL have ports: wb_stall  output  1  writeback result not accepted this cycle; stage holds it.
REQ-008 SHALL have ports: mc_issue  input  1  multi-cycle op dispatched this cycle.
REQ-009 SHALL have ports: mc_issue_addr  input  4  destination of dispatched multi-cycle op.
REQ-010 SHALL have ports: mc_valid  input  1  multi-cycle unit presents a result.
REQ-011 SHALL have ports: mc_addr  input  4  multi-cycle result destination.
REQ-012 SHALL have ports: mc_data  input  16  multi-cycle result data.
REQ-013 SHALL have ports: mc_ready  output  1  result buffer can accept (count < 2).
REQ-014 SHALL have ports: rf_we, rf_waddr[3:0], rf_wdata[15:0]  output  register-file write port, registered.
REQ-015 SHALL have ports: pending  output  16  per-register outstanding multi-cycle write scoreboard.

Function
REQ-016 SHALL buffer multi-cycle results in a 2-entry FIFO; push on mc_valid && mc_ready; mc_ready depends on count only, never on same-cycle pop.
REQ-017 SHALL route every multi-cycle result through the FIFO (no bypass); min mc_valid-to-rf_we latency 2 cycles.
REQ-018 SHALL grant the write port each cycle to exactly one source: FIFO head if state==DRAIN, else WB if wb_valid, else FIFO head if non-empty, else none.
REQ-019 SHALL drive wb_stall = wb_valid && grant != WB, combinationally.
REQ-020 SHALL register the granted addr/data onto rf_waddr/rf_wdata and set rf_we=1 on the next edge; WB-to-rf_we latency 1 cycle; rf_we=0 when no grant (addr/data hold last value).
REQ-021 SHALL pop the FIFO head on a cycle it is granted; simultaneous push and pop at count==1 leaves count==1 with new entry at head.
REQ-022 SHALL keep an age counter: 0 when FIFO empty or on pop; else +1 per cycle, saturating at AGE_LIMIT.
REQ-023 SHALL implement states PIPE and DRAIN: PIPE->DRAIN when count==2 or age==AGE_LIMIT (evaluated on registered values); DRAIN->PIPE after the cycle in which FIFO becomes empty or after 2 pops in DRAIN, whichever first.
REQ-024 SHALL set pending[mc_issue_addr] on mc_issue; clear pending[a] when a FIFO entry with address a is written via rf_we; set wins over same-cycle clear of the same bit.
REQ-025 SHALL leave pending unchanged by WB-sourced writes; re-issue to a pending register keeps bit at 1.
REQ-026 SHALL treat register 0 like any other address.

Reset
REQ-027 SHALL on rst=1 at an edge: state PIPE, FIFO count 0 (contents discarded), age 0, pending 16'h0000, rf_we 0, rf_waddr 0, rf_wdata 0.
REQ-028 SHALL during rst=1 drive mc_ready 0 and wb_stall = wb_valid; reset mid-operation drops any buffered result without writing it.

Verification
REQ-029 SHALL cover: wb_valid=1, wb_addr=3, wb_data=16'h00AA, FIFO empty -> wb_stall=0, next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h00AA.
REQ-030 SHALL cover: mc_issue addr 5 then mc_valid addr 5 data 16'h1234 with wb_valid=0 -> pending[5]=1, rf_we with 5/16'h1234 exactly 2 cycles after mc_valid, pending[5]=0 the following cycle.
REQ-031 SHALL cover: wb_valid held 1 continuously, one mc result pushed -> WB written 4 (AGE_LIMIT) cycles, then DRAIN: wb_stall=1 one cycle, FIFO entry written, WB resumes.
REQ-032 SHALL cover: two mc results on consecutive cycles with wb_valid=1 -> count==2, mc_ready=0, DRAIN pops both back-to-back, wb_stall=1 for 2 cycles.
REQ-033 SHALL cover: mc_issue addr 7 same cycle as FIFO write of addr 7 -> pending[7] stays 1.
REQ-034 SHALL cover: rst asserted with count==2 and pending=16'h0060 -> after edge count 0, pending 0, rf_we 0, no buffered write ever appears.
